// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-word add/subtract engine around one shared 32-bit CLA slice
// One 32-bit word per cycle goes through the slice, LSW first, with the carry held between words.

module CLA_index_4_32_block (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  // 4-bit lookahead groups; group carry-out uses group generate/propagate
  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    logic gg;
    logic pg;
    assign gg = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
              | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign pg = &p[B+3:B];
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = gg | (pg & c[B]);
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDS*32-1:0] op_a,
  input  logic [WORDS*32-1:0] op_b,
  input  logic               sub,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDS*32-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic               busy
);

  localparam int N  = WORDS * 32;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    acc_q;
  logic [N-1:0]    sum_q;
  logic [IW-1:0]   idx;
  logic [IW+4:0]   base;
  logic            carry_reg;
  logic            cout_q;
  logic            ovf_q;
  logic            accept;
  logic            last;
  logic [31:0]     slice_a;
  logic [31:0]     slice_b;
  logic [31:0]     slice_sum;
  logic            slice_cout;

  assign base    = {idx, 5'd0};
  assign slice_a = a_q[base +: 32];
  assign slice_b = b_q[base +: 32];
  assign accept  = in_valid && (state_q == IDLE);
  assign last    = (state_q == RUN) && (idx == IW'(WORDS - 1));

  CLA_index_4_32_block u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Subtraction is A + ~B + ~borrow; results land in the output registers only on the last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      a_q       <= op_a;
      b_q       <= sub ? ~op_b : op_b;
      carry_reg <= cin ^ sub;
      idx       <= '0;
    end else if (state_q == RUN) begin
      acc_q[base +: 32] <= slice_sum;
      carry_reg         <= slice_cout;
      if (last) begin
        sum_q  <= {slice_sum, acc_q[N-33:0]};
        cout_q <= slice_cout;
        ovf_q  <= (slice_a[31] ^ slice_b[31] ^ slice_sum[31]) ^ slice_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - directed self-checking bench for wide_add_sequencer
// Hand-computed vectors plus a small arithmetic model for the back-to-back phase.

module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int N     = WORDS * 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks  = 0;
  int errors  = 0;
  int cyc_cnt = 0;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; returns cycles from the accept cycle to first out_valid
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input logic c, output int lat);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("issue_ready", N'(in_ready), N'(1));
    op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ov_drop", N'(out_valid), N'(0));
  endtask

  logic [N-1:0] all1;
  logic [N-1:0] maxpos;
  logic [N-1:0] minneg;
  logic [N-1:0] ra [3];
  logic [N-1:0] rb [3];
  logic         rs [3];
  logic         rc [3];
  int           acc_cyc [3];
  int           lat;
  int           waited;
  logic [N:0]   full;
  logic [N-1:0] es;
  logic         ec;
  logic         eo;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    all1   = '1;
    maxpos = {1'b0, {(N-1){1'b1}}};
    minneg = {1'b1, {(N-1){1'b0}}};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    #2;
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_out_valid", N'(out_valid), N'(0));
    check("rst_busy", N'(busy), N'(0));
    check("rst_sum", sum, '0);
    check("rst_cout", N'(cout), N'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(all1, N'(1), 1'b0, 1'b0, lat);
    check("t1_lat", N'(lat), N'(WORDS + 1));
    check("t1_sum", sum, '0);
    check("t1_cout", N'(cout), N'(1));
    check("t1_ovf", N'(ovf), N'(0));
    check("t1_busy", N'(busy), N'(1));
    release_out();

    issue('0, N'(1), 1'b1, 1'b0, lat);
    check("t2a_sum", sum, all1);
    check("t2a_cout", N'(cout), N'(0));
    check("t2a_ovf", N'(ovf), N'(0));
    release_out();
    issue(N'(5), N'(3), 1'b1, 1'b1, lat);
    check("t2b_sum", sum, N'(1));
    check("t2b_cout", N'(cout), N'(1));
    release_out();

    issue(maxpos, N'(1), 1'b0, 1'b0, lat);
    check("t3a_sum", sum, minneg);
    check("t3a_ovf", N'(ovf), N'(1));
    check("t3a_cout", N'(cout), N'(0));
    release_out();
    issue(minneg, N'(1), 1'b1, 1'b0, lat);
    check("t3b_sum", sum, maxpos);
    check("t3b_ovf", N'(ovf), N'(1));
    check("t3b_cout", N'(cout), N'(1));
    release_out();

    issue(N'(123), N'(456), 1'b0, 1'b0, lat);
    op_a = all1; op_b = all1; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t4_ov", N'(out_valid), N'(1));
      check("t4_sum", sum, N'(579));
      check("t4_cout", N'(cout), N'(0));
      check("t4_in_ready", N'(in_ready), N'(0));
    end
    in_valid = 1'b0;
    release_out();
    check("t4_hold_sum", sum, N'(579));
    check("t4_idle", N'(busy), N'(0));

    op_a = all1; op_b = all1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_ov", N'(out_valid), N'(0));
    check("t5_busy", N'(busy), N'(0));
    check("t5_in_ready", N'(in_ready), N'(1));
    check("t5_sum_clr", sum, '0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(N'(1), N'(1), 1'b0, 1'b0, lat);
    check("t5_lat", N'(lat), N'(WORDS + 1));
    check("t5_sum", sum, N'(2));
    release_out();

    for (int i = 0; i < 3; i++) begin
      ra[i] = {$urandom, $urandom, $urandom, $urandom};
      rb[i] = {$urandom, $urandom, $urandom, $urandom};
      rs[i] = i[0];
      rc[i] = (i == 2);
    end
    out_ready = 1'b1;
    op_a = ra[0]; op_b = rb[0]; sub = rs[0]; cin = rc[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waited = 0;
      while (!in_ready && waited < 50) begin
        @(posedge clk); #1;
        waited++;
      end
      check("t6_ready", N'(in_ready), N'(1));
      acc_cyc[i] = cyc_cnt;
      @(posedge clk); #1;
      if (i < 2) begin
        op_a = ra[i+1]; op_b = rb[i+1]; sub = rs[i+1]; cin = rc[i+1];
      end else begin
        in_valid = 1'b0;
      end
      waited = 0;
      while (!out_valid && waited < 50) begin
        @(posedge clk); #1;
        waited++;
      end
      if (!rs[i]) begin
        full = {1'b0, ra[i]} + {1'b0, rb[i]} + (N+1)'(rc[i]);
        es   = full[N-1:0];
        ec   = full[N];
        eo   = (ra[i][N-1] == rb[i][N-1]) && (es[N-1] != ra[i][N-1]);
      end else begin
        es = ra[i] - rb[i] - N'(rc[i]);
        ec = ({1'b0, ra[i]} >= ({1'b0, rb[i]} + (N+1)'(rc[i])));
        eo = (ra[i][N-1] != rb[i][N-1]) && (es[N-1] != ra[i][N-1]);
      end
      check("t6_sum", sum, es);
      check("t6_cout", N'(cout), N'(ec));
      check("t6_ovf", N'(ovf), N'(eo));
      if (i > 0) check("t6_spacing", N'(acc_cyc[i] - acc_cyc[i-1]), N'(WORDS + 2));
    end
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
